// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the req_encoder_n request encoder.
package req_enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_HOLD
  } state_e;

  // Index after idx, wrapping to 0 past the last line (handles non-power-of-two widths).
  function automatic int unsigned ptr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/req_enc_pick.sv
// Combinational winner search: first set request at or after start, wrapping around.
module req_enc_pick #(
  parameter int unsigned N_LINES = 8,
  localparam int unsigned OUT_W = $clog2(N_LINES)
) (
  input  logic [N_LINES-1:0] req,
  input  logic [OUT_W-1:0]   start,
  output logic [OUT_W-1:0]   idx,
  output logic               any
);

  logic [OUT_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = 0; k < N_LINES; k++) begin
      pos = OUT_W'((32'(start) + k) % N_LINES);
      if (!any && req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder_n.sv
// Registered N-to-log2(N) request encoder with ready/valid output and fixed or round-robin
// arbitration. Define REQ_ENC_MULTIHOT_DET_EN to add the registered multi_hot flag.
module req_encoder_n
  import req_enc_pkg::*;
#(
  parameter int unsigned N_LINES = 8,
  parameter int unsigned RR_MODE = 0,
  localparam int unsigned OUT_W = $clog2(N_LINES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] in_lines,
  output logic [OUT_W-1:0]   out_lines,
  output logic               out_valid,
  input  logic               out_ready
`ifdef REQ_ENC_MULTIHOT_DET_EN
  ,
  output logic               multi_hot
`endif
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] lines_q, lines_d;
  logic [OUT_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic             handshake;
  logic             capture;
  logic [OUT_W-1:0] next_ptr;
  logic [OUT_W-1:0] start;
  logic [OUT_W-1:0] pick_idx;
  logic             pick_any;

  assign handshake = valid_q && out_ready;
  assign next_ptr  = OUT_W'(ptr_wrap_inc(32'(lines_q), N_LINES));
  // A capture during a handshake already searches from the post-accept pointer.
  assign start     = (RR_MODE == 0) ? '0 : (handshake ? next_ptr : ptr_q);

  req_enc_pick #(
    .N_LINES(N_LINES)
  ) u_pick (
    .req  (in_lines),
    .start(start),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    lines_d = lines_q;
    ptr_d   = ptr_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          capture = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          ptr_d = next_ptr;
          if (pick_any) begin
            capture = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      lines_d = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      lines_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lines_q <= lines_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_lines = lines_q;
  assign out_valid = valid_q;

`ifdef REQ_ENC_MULTIHOT_DET_EN
  logic multi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_q <= 1'b0;
    end else if (capture) begin
      multi_q <= ($countones(in_lines) > 1);
    end
  end

  assign multi_hot = multi_q;
`endif

endmodule
